// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B multi-pixel receiver.
// Defining WS2812B_RGBW_EN selects 4 bytes per pixel (G,R,B,W) instead of 3 (G,R,B).
package ws2812b_pkg;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_FORWARD = 1'b1
    } state_t;

`ifdef WS2812B_RGBW_EN
    localparam int BPP = 4;
`else
    localparam int BPP = 3;
`endif

    // The status register lives at the all-ones read address; truncate to ADDR_W at use.
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/ws2812b_bit_decoder.sv
// WS2812B line decoder: measures each high pulse to produce one bit per falling edge,
// and flags a latch gap once din has stayed low for IDLE_CYCLES.
module ws2812b_bit_decoder #(
    parameter int THRESHOLD_CYCLES = 38,
    parameter int IDLE_CYCLES      = 3840
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic bit_valid,
    output logic bit_value,
    output logic idle
);

    localparam int HC_W = $clog2(THRESHOLD_CYCLES + 1);
    localparam int IC_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [HC_W-1:0] HC_SAT = HC_W'(THRESHOLD_CYCLES);
    localparam logic [IC_W-1:0] IC_SAT = IC_W'(IDLE_CYCLES);
    localparam logic [IC_W-1:0] IC_PRE = IC_W'(IDLE_CYCLES - 1);

    logic [HC_W-1:0] r_high_cnt;
    logic [IC_W-1:0] r_idle_cnt;
    logic            r_din_prev;
    logic            r_bit_valid;
    logic            r_bit_value;
    logic            r_idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_din_prev  <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_value <= 1'b0;
            r_idle      <= 1'b0;
        end else begin
            r_din_prev  <= din;
            r_bit_valid <= r_din_prev & ~din;
            // Saturation at the threshold makes ">= THRESHOLD" a simple equality test.
            r_bit_value <= (r_high_cnt == HC_SAT);

            if (!din)
                r_high_cnt <= '0;
            else if (r_high_cnt != HC_SAT)
                r_high_cnt <= r_high_cnt + 1'b1;

            if (din)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != IC_SAT)
                r_idle_cnt <= r_idle_cnt + 1'b1;

            // Single pulse on the cycle the low-run reaches IDLE_CYCLES; silent while saturated.
            r_idle <= ~din & (r_idle_cnt == IC_PRE);
        end
    end

    assign bit_valid = r_bit_valid;
    assign bit_value = r_bit_value;
    assign idle      = r_idle;

endmodule

// File: rtl/ws2812b_multi_rx.sv
// Captures the first NUM_PIXELS pixels of a WS2812B stream into a readable buffer and
// forwards the rest downstream. WS2812B_RGBW_EN (see ws2812b_pkg) selects 4-byte pixels.
module ws2812b_multi_rx
    import ws2812b_pkg::*;
#(
    parameter int CLK_HZ           = 64000000,
    parameter int THRESHOLD_CYCLES = 38,
    parameter int IDLE_CYCLES      = 3840,
    parameter int NUM_PIXELS       = 4,
    parameter int ADDR_W           = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic              dout,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              clear,
    output logic              frame_ready
);

    localparam int NBYTES = NUM_PIXELS * BPP;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int BUF_AW = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] BPP_IDX  = IDX_W'(BPP);

    generate
        if (CLK_HZ <= 0 || NUM_PIXELS < 1 || NUM_PIXELS > 16 || (2 ** ADDR_W) <= NBYTES) begin : g_param_check
            $error("ws2812b_multi_rx: illegal parameter combination");
        end
    endgenerate

    logic [7:0]       r_buf [0:NBYTES-1];
    state_t           r_state;
    logic [IDX_W-1:0] r_index;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_shift;
    logic             r_dout;
    logic             r_frame_ready;
    logic             r_overflow;
    logic [4:0]       r_pixel_count;

    logic              w_bit_valid;
    logic              w_bit_value;
    logic              w_idle;
    logic              w_byte_valid;
    logic              w_wr_en;
    logic              w_fr_set;
    logic              w_ov_set;
    logic [7:0]        w_byte;
    logic [4:0]        w_pix_done;
    logic [BUF_AW-1:0] w_wr_ptr;
    logic [BUF_AW-1:0] w_rd_ptr;

    ws2812b_bit_decoder #(
        .THRESHOLD_CYCLES (THRESHOLD_CYCLES),
        .IDLE_CYCLES      (IDLE_CYCLES)
    ) u_decoder (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .bit_valid (w_bit_valid),
        .bit_value (w_bit_value),
        .idle      (w_idle)
    );

    // The eighth bit completes the byte in the same cycle it arrives.
    assign w_byte_valid = w_bit_valid & (r_bit_cnt == 3'd7);
    assign w_byte       = {r_shift, w_bit_value};
    assign w_wr_en      = w_byte_valid & (r_state == ST_CAPTURE) & ~w_idle;
    assign w_fr_set     = w_idle & (r_index >= BPP_IDX);
    assign w_ov_set     = w_wr_en & r_frame_ready;
    assign w_pix_done   = 5'(32'(r_index) / BPP);
    assign w_wr_ptr     = r_index[BUF_AW-1:0];
    assign w_rd_ptr     = rd_addr[BUF_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_CAPTURE;
            r_index       <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_dout        <= 1'b0;
            r_frame_ready <= 1'b0;
            r_overflow    <= 1'b0;
            r_pixel_count <= '0;
        end else begin
            // Set events take priority over a coincident clear.
            r_frame_ready <= w_fr_set | (r_frame_ready & ~clear);
            r_overflow    <= w_ov_set | (r_overflow & ~clear);
            if (w_fr_set)
                r_pixel_count <= w_pix_done;

            if (w_idle) begin
                r_state   <= ST_CAPTURE;
                r_index   <= '0;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_dout    <= 1'b0;
            end else begin
                r_dout <= (r_state == ST_FORWARD) ? din : 1'b0;
                if (w_bit_valid) begin
                    r_shift   <= {r_shift[5:0], w_bit_value};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (r_state == ST_CAPTURE && w_wr_en) begin
                    r_index <= r_index + 1'b1;
                    if (r_index == LAST_IDX)
                        r_state <= ST_FORWARD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBYTES; i++)
                r_buf[i] <= 8'h00;
        end else if (w_wr_en) begin
            r_buf[w_wr_ptr] <= w_byte;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (32'(rd_addr) < NBYTES)
            rd_data = r_buf[w_rd_ptr];
        else if (rd_addr == STATUS_ADDR[ADDR_W-1:0])
            rd_data = {r_frame_ready, r_overflow, 1'b0, r_pixel_count};
    end

    assign dout        = r_dout;
    assign frame_ready = r_frame_ready;

endmodule

// File: tb/tb_ws2812b_multi_rx.sv
// Directed bench for ws2812b_multi_rx: capture, forwarding, idle/latch, flags, reset.
// Build with WS2812B_RGBW_EN defined to exercise 4-byte pixels.
module tb_ws2812b_multi_rx;

    localparam int IDLE = 3840;
`ifdef WS2812B_RGBW_EN
    localparam int TB_BPP = 4;
`else
    localparam int TB_BPP = 3;
`endif
    localparam int TB_NB = 4 * TB_BPP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] rd_addr = 6'd0;
    logic       dout;
    logic [7:0] rd_data;
    logic       frame_ready;

    int checks = 0;
    int errors = 0;
    int mon_mode = 0;   // 0 none, 1 dout must stay 0, 2 dout must be din delayed one clock
    int mon_err = 0;
    int last_low = 0;

    always #5 clk = ~clk;

    ws2812b_multi_rx #(
        .CLK_HZ           (64000000),
        .THRESHOLD_CYCLES (38),
        .IDLE_CYCLES      (IDLE),
        .NUM_PIXELS       (4),
        .ADDR_W           (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .dout        (dout),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .clear       (clear),
        .frame_ready (frame_ready)
    );

    task automatic tick();
        @(negedge clk);
        if (mon_mode == 1 && dout !== 1'b0) mon_err++;
        if (mon_mode == 2 && dout !== din) mon_err++;
    endtask

    task automatic set_din(input logic v);
        logic old;
        old = din;
        din = v;
        #1;
        if (mon_mode == 2 && dout !== old) mon_err++;
    endtask

    task automatic send_bit_raw(input int h, input int l);
        set_din(1'b1);
        repeat (h) tick();
        set_din(1'b0);
        repeat (l) tick();
        last_low = l;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) send_bit_raw(48, 32);
            else      send_bit_raw(20, 60);
        end
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(first + 8'(i));
    endtask

    task automatic idle_gap();
        repeat (4000) tick();
    endtask

    task automatic read_addr(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic do_reset();
        din = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", dout); end
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready got %b want 0", frame_ready); end
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", d); end
        read_addr(6'd0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_buf0 got %h want 00", d); end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_frame();
        logic [7:0] d;
        send_bytes(8'h01, TB_NB);
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL frame_ready_before_idle got %b want 0", frame_ready); end
        idle_gap();
        for (int a = 0; a < TB_NB; a++) begin
            read_addr(6'(a), d);
            checks++;
            if (d !== 8'(a + 1)) begin errors++; $display("FAIL frame_buf%0d got %h want %h", a, d, 8'(a + 1)); end
        end
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h84) begin errors++; $display("FAIL frame_status got %h want 84", d); end
        read_addr(6'd62, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL frame_unmapped got %h want 00", d); end
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL frame_ready got %b want 1", frame_ready); end
        $display("test_frame done: %0d bytes", TB_NB);
    endtask

    task automatic test_second_frame();
        logic [7:0] d;
        send_bytes(8'hA0, TB_NB);
        idle_gap();
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'hC4) begin errors++; $display("FAIL second_status got %h want c4", d); end
        read_addr(6'd0, d);
        checks++;
        if (d !== 8'hA0) begin errors++; $display("FAIL second_buf0 got %h want a0", d); end
        $display("test_second_frame done");
    endtask

    task automatic test_clear_with_idle();
        logic [7:0] d;
        send_bytes(8'h11, TB_BPP);
        repeat (IDLE - last_low) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h81) begin errors++; $display("FAIL clear_idle_status got %h want 81", d); end
        read_addr(6'd0, d);
        checks++;
        if (d !== 8'h11) begin errors++; $display("FAIL clear_idle_buf0 got %h want 11", d); end
        read_addr(6'(TB_BPP), d);
        checks++;
        if (d !== 8'hA0 + 8'(TB_BPP)) begin errors++; $display("FAIL clear_idle_buf_kept got %h want %h", d, 8'hA0 + 8'(TB_BPP)); end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL clear_status got %h want 01", d); end
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL clear_frame_ready got %b want 0", frame_ready); end
        $display("test_clear_with_idle done");
    endtask

    task automatic test_partial();
        logic [7:0] d;
        do_reset();
        send_bytes(8'h51, 5);
        idle_gap();
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL partial_frame_ready got %b want 1", frame_ready); end
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h81) begin errors++; $display("FAIL partial_status got %h want 81", d); end
        read_addr(6'd3, d);
        checks++;
        if (d !== 8'h54) begin errors++; $display("FAIL partial_buf3 got %h want 54", d); end
        read_addr(6'd4, d);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL partial_buf4 got %h want 55", d); end
        $display("test_partial done");
    endtask

    task automatic test_threshold();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) send_bit_raw((i % 2 == 0) ? 38 : 37, 60);
        for (int i = 0; i < 8; i++) send_bit_raw((i % 2 == 0) ? 37 : 38, 60);
        send_bytes(8'h00, TB_BPP - 2);
        idle_gap();
        read_addr(6'd0, d);
        checks++;
        if (d !== 8'hAA) begin errors++; $display("FAIL threshold_byte0 got %h want aa", d); end
        read_addr(6'd1, d);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL threshold_byte1 got %h want 55", d); end
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h81) begin errors++; $display("FAIL threshold_status got %h want 81", d); end
        $display("test_threshold done");
    endtask

    task automatic test_forward();
        logic [7:0] d;
        do_reset();
        mon_err = 0;
        mon_mode = 1;
        send_bytes(8'h01, TB_NB);
        mon_mode = 0;
        checks++;
        if (mon_err !== 0) begin errors++; $display("FAIL capture_dout_zero got %0d bad cycles want 0", mon_err); end
        mon_err = 0;
        mon_mode = 2;
        send_bytes(8'h01 + 8'(TB_NB), 3);
        mon_mode = 0;
        checks++;
        if (mon_err !== 0) begin errors++; $display("FAIL forward_delay got %0d bad cycles want 0", mon_err); end
        idle_gap();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL forward_dout_after_idle got %b want 0", dout); end
        for (int a = 0; a < TB_NB; a++) begin
            read_addr(6'(a), d);
            checks++;
            if (d !== 8'(a + 1)) begin errors++; $display("FAIL forward_buf%0d got %h want %h", a, d, 8'(a + 1)); end
        end
        read_addr(6'(TB_NB), d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL forward_past_end got %h want 00", d); end
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h84) begin errors++; $display("FAIL forward_status got %h want 84", d); end
        $display("test_forward done");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        send_bit_raw(48, 32);
        send_bit_raw(20, 60);
        send_bit_raw(48, 32);
        send_bit_raw(48, 32);
        send_bit_raw(20, 60);
        rd_addr = 6'h3F;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_status got %h want 00", rd_data); end
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL midreset_frame_ready got %b want 0", frame_ready); end
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL midreset_dout got %b want 0", dout); end
        rd_addr = 6'd0;
        #1;
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_buf0 got %h want 00", rd_data); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_bytes(8'h21, TB_NB);
        idle_gap();
        for (int a = 0; a < TB_NB; a++) begin
            read_addr(6'(a), d);
            checks++;
            if (d !== 8'h21 + 8'(a)) begin errors++; $display("FAIL midreset_buf%0d got %h want %h", a, d, 8'h21 + 8'(a)); end
        end
        read_addr(6'h3F, d);
        checks++;
        if (d !== 8'h84) begin errors++; $display("FAIL midreset_frame_status got %h want 84", d); end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_second_frame();
        test_clear_with_idle();
        test_partial();
        test_threshold();
        test_forward();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
